// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame constants and the receiver state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous bit.
// Every stage resets to RESET_VAL so an idle-high line looks idle straight out of reset.
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the input through the chain; the shift form also works for a single stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= (r_sync << 1) | STAGES'(i_d);
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 1 start bit, DATA_BITS data bits (LSB first), 1 stop bit.
// All state advances only on rx_tick; the line is sampled at the middle of each bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    // Half a bit into the start bit, and a full bit period for data/stop bits.
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 w_rx_s;

    rx_state_t            r_state,    w_state_d;
    logic [TW-1:0]        r_tick_cnt, w_tick_cnt_d;
    logic [BW-1:0]        r_bit_cnt,  w_bit_cnt_d;
    logic [DATA_BITS-1:0] r_shift,    w_shift_d;
    logic [DATA_BITS-1:0] r_data,     w_data_d;
    logic                 r_valid,    w_valid_d;
    logic                 r_ferr,     w_ferr_d;
    logic                 r_rx_prev,  w_rx_prev_d;

    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    // Next-state logic; everything holds unless this cycle carries a tick.
    always_comb begin
        w_state_d    = r_state;
        w_tick_cnt_d = r_tick_cnt;
        w_bit_cnt_d  = r_bit_cnt;
        w_shift_d    = r_shift;
        w_data_d     = r_data;
        w_valid_d    = 1'b0;
        w_ferr_d     = 1'b0;
        w_rx_prev_d  = r_rx_prev;

        if (rx_tick) begin
            // Tracking the line on every tick means a held-low break never looks like an edge.
            w_rx_prev_d = w_rx_s;

            unique case (r_state)
                RxIdle: begin
                    if (!w_rx_s && r_rx_prev) begin
                        w_state_d    = RxStart;
                        w_tick_cnt_d = '0;
                    end
                end

                RxStart: begin
                    if (r_tick_cnt == TICK_HALF) begin
                        w_tick_cnt_d = '0;
                        if (!w_rx_s) begin
                            w_state_d   = RxData;
                            w_bit_cnt_d = '0;
                        end else begin
                            // Glitch shorter than half a bit: drop it silently.
                            w_state_d = RxIdle;
                        end
                    end else begin
                        w_tick_cnt_d = r_tick_cnt + 1'b1;
                    end
                end

                RxData: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt_d = '0;
                        w_shift_d    = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_state_d   = RxStop;
                            w_bit_cnt_d = '0;
                        end else begin
                            w_bit_cnt_d = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_d = r_tick_cnt + 1'b1;
                    end
                end

                RxStop: begin
                    if (r_tick_cnt == TICK_LAST) begin
                        w_tick_cnt_d = '0;
                        // The word is published even on a bad stop bit.
                        w_data_d     = r_shift;
                        w_valid_d    = w_rx_s;
                        w_ferr_d     = !w_rx_s;
                        w_state_d    = RxIdle;
                    end else begin
                        w_tick_cnt_d = r_tick_cnt + 1'b1;
                    end
                end

                default: begin
                    w_state_d    = RxIdle;
                    w_tick_cnt_d = '0;
                    w_bit_cnt_d  = '0;
                end
            endcase
        end
    end

    // State and output registers; reset wins over any tick in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= RxIdle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_rx_prev  <= 1'b1;
        end else begin
            r_state    <= w_state_d;
            r_tick_cnt <= w_tick_cnt_d;
            r_bit_cnt  <= w_bit_cnt_d;
            r_shift    <= w_shift_d;
            r_data     <= w_data_d;
            r_valid    <= w_valid_d;
            r_ferr     <= w_ferr_d;
            r_rx_prev  <= w_rx_prev_d;
        end
    end

    assign data_out      = r_data;
    assign data_valid    = r_valid;
    assign framing_error = r_ferr;
    assign busy          = (r_state != RxIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven on the serial line, expected words are
// queued as each frame is issued, and a monitor pops and compares on every output pulse.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam real BIT_NS  = 640.0;   // 16 ticks x 4 clk x 10 ns
    localparam real FAST_NS = 620.8;   // 3% fast
    localparam real SLOW_NS = 659.2;   // 3% slow

    typedef struct {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    uart_rx #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_tick       (rx_tick),
        .rx            (rx),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Baud tick: one clk high out of every four.
    initial begin
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            rx_tick = (cnt == 3);
            cnt = (cnt + 1) % 4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Move off the clock edges so line transitions never race the sampling flop.
    task automatic align();
        @(negedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input real bit_ns);
        exp_t e;
        e.data = d;
        e.ferr = !stop;
        exp_q.push_back(e);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    // Monitor: every output pulse consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (data_valid || framing_error)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: data_valid=%0b framing_error=%0b data_out=0x%0h, required no pulse at %0t",
                         data_valid, framing_error, data_out, $time);
            end else begin
                e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("data_valid", 32'(data_valid), 32'(!e.ferr));
                chk("framing_error", 32'(framing_error), 32'(e.ferr));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (5) @(negedge clk);
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_framing_error", 32'(framing_error), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        #(BIT_NS);

        // Single good frame, then idle.
        align();
        send_frame(8'h55, 1'b1, BIT_NS);
        chk("busy_after_55", 32'(busy), 32'h0);
        #(BIT_NS);

        // Back-to-back frames.
        align();
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
        #(BIT_NS);

        // False start: 4 ticks low.
        align();
        rx = 1'b0;
        #160;
        rx = 1'b1;
        #40;
        chk("false_start_busy_mid", 32'(busy), 32'h1);
        #240;
        chk("false_start_busy_end", 32'(busy), 32'h0);
        #(2 * BIT_NS);

        // Bad stop bit, then the line stays low (break).
        align();
        send_frame(8'h3C, 1'b0, BIT_NS);
        for (int i = 0; i < 3; i++) begin
            chk("break_busy", 32'(busy), 32'h0);
            #(BIT_NS);
        end
        rx = 1'b1;
        #(BIT_NS);
        align();
        send_frame(8'h81, 1'b1, BIT_NS);
        #(BIT_NS);

        // Reset partway through 0xA3 (start bit plus data bits 0..3 sent).
        align();
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = 1'((8'hA3 >> i) & 8'h01);
            #(BIT_NS);
        end
        chk("busy_before_reset", 32'(busy), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        chk("midrst_data_out", 32'(data_out), 32'h0);
        chk("midrst_data_valid", 32'(data_valid), 32'h0);
        chk("midrst_framing_error", 32'(framing_error), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        #(2 * BIT_NS);
        align();
        send_frame(8'hA3, 1'b1, BIT_NS);
        #(BIT_NS);

        // Baud tolerance.
        align();
        send_frame(8'hA5, 1'b1, FAST_NS);
        #(BIT_NS);
        align();
        send_frame(8'hA5, 1'b1, SLOW_NS);
        #(2 * BIT_NS);

        chk("pending_expectations", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning rx_tick pulses per bit period (even, >=8).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop stages on rx.
REQ-004 SHALL have port: clk  input  1  system clock; the only clock.
REQ-005 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: rx_tick  input  1  one-clk strobe at OVERSAMPLE x baud, from the baud generator.
REQ-007 SHALL have port: rx  input  1  asynchronous serial line; idle high.
REQ-008 SHALL have port: data_out  output  DATA_BITS  last received word, LSB = first bit.
REQ-009 SHALL have port: data_valid  output  1  one-clk pulse; data_out holds a good frame.
REQ-010 SHALL have port: framing_error  output  1  one-clk pulse; stop bit sampled low.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass rx through SYNC_STAGES flops (rx_s); all decisions use rx_s only.
REQ-013 SHALL advance the FSM and the tick counter only on clk edges where rx_tick=1; other cycles hold state.
REQ-014 SHALL implement states IDLE, START, DATA, STOP.
REQ-015 IDLE: on a tick with rx_s=0 and previous-tick rx_s=1 (falling edge) SHALL go to START with tick_cnt=0.
REQ-016 START: SHALL count ticks; at tick_cnt=OVERSAMPLE/2-1 it SHALL go to DATA (tick_cnt=0, bit_cnt=0) if rx_s=0, else to IDLE (false start, no output pulse).
REQ-017 DATA: SHALL sample rx_s into the shift register at tick_cnt=OVERSAMPLE-1 (mid-bit), LSB-first, and increment bit_cnt; after bit DATA_BITS-1 it SHALL go to STOP.
REQ-018 STOP: at tick_cnt=OVERSAMPLE-1 SHALL load data_out from the shift register and return to IDLE.
REQ-019 STOP sample rx_s=1 SHALL pulse data_valid; rx_s=0 SHALL pulse framing_error; never both.
REQ-020 data_valid/framing_error SHALL be registered, high exactly one clk, in the cycle after the clk edge of the STOP sampling tick.
REQ-021 data_out SHALL hold its value until the next STOP sample, including while a new frame is received.
REQ-022 After a framing error (line held low/break), a new frame SHALL start only after rx_s has been seen high on at least one tick.
REQ-023 Counters SHALL be $clog2(OVERSAMPLE) and $clog2(DATA_BITS+1) bits wide, wrap to 0 explicitly, never overflow.
REQ-024 Back-to-back frames (next start bit immediately after stop bit) SHALL be received without loss.

Reset
REQ-025 reset SHALL force state IDLE, counters 0, shift register 0, data_out 0, data_valid 0, framing_error 0, busy 0, sync flops and previous-rx register 1.
REQ-026 reset mid-frame SHALL abandon the frame with no output pulse; reset dominates rx_tick in the same cycle.

Structure
REQ-027 A shared package uart_pkg SHALL hold the rx state enum typedef and default constants DATA_BITS and OVERSAMPLE, shared with uart_tx.
REQ-028 The synchronizer SHALL be a sub-module sync_ff (parameterised depth, reset value 1).

Verification (DATA_BITS=8, OVERSAMPLE=16, rx_tick every 4 clk)
REQ-029 Frame 0x55 with good stop -> data_out=0x55, data_valid high exactly 1 clk, framing_error 0, busy low afterwards.
REQ-030 Frames 0x00 then 0xFF back-to-back -> two data_valid pulses, data_out 0x00 then 0xFF.
REQ-031 rx low for 4 ticks then high -> no pulses, busy returns 0 within 8 ticks of the falling edge.
REQ-032 Frame 0x3C with stop bit low -> framing_error 1 clk, data_valid 0, data_out=0x3C; line held low -> no new frame until rx returns high.
REQ-033 reset asserted after bit 3 of 0xA3 -> all outputs 0 next clk; a following 0xA3 frame -> data_out=0xA3, data_valid pulse.
REQ-034 Baud 3% fast and 3% slow on frame 0xA5 -> data_out=0xA5, data_valid pulse in both cases.
